// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers: exception
// codes, flush vector and the payload field layout every stage packs/unpacks.
package pipe_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  localparam logic [31:0] FLUSH_PC_DEFAULT = 32'h0000_0000;

  // Payload layout: {ctrl, rt_val, rs_val, imm16, instr}
  localparam int PL_INSTR_LSB = 0;
  localparam int PL_INSTR_W   = 32;
  localparam int PL_IMM_LSB   = 32;
  localparam int PL_IMM_W     = 16;
  localparam int PL_RS_LSB    = 48;
  localparam int PL_RS_W      = 32;
  localparam int PL_RT_LSB    = 80;
  localparam int PL_RT_W      = 32;
  localparam int PL_CTRL_LSB  = 112;
  localparam int PL_CTRL_W    = 16;
  localparam int PL_W         = 128;

  function automatic logic [PL_W-1:0] pack_payload(
    input logic [PL_CTRL_W-1:0]  ctrl,
    input logic [PL_RT_W-1:0]    rt_val,
    input logic [PL_RS_W-1:0]    rs_val,
    input logic [PL_IMM_W-1:0]   imm,
    input logic [PL_INSTR_W-1:0] instr
  );
    return {ctrl, rt_val, rs_val, imm, instr};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register entry {valid, data, pc, bd, exc, exccode} with
// synchronous reset, clear (pc loads clear_pc), load and hold.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [PC_W-1:0]   clear_pc,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]   d_pc,
  input  logic              d_bd,
  input  logic              d_exc,
  input  logic [EXC_W-1:0]  d_exccode,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [PC_W-1:0]   q_pc,
  output logic              q_bd,
  output logic              q_exc,
  output logic [EXC_W-1:0]  q_exccode
);

  // Entry state: reset > clear > load > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid   <= 1'b0;
      q_data    <= {DATA_W{1'b0}};
      q_pc      <= {PC_W{1'b0}};
      q_bd      <= 1'b0;
      q_exc     <= 1'b0;
      q_exccode <= {EXC_W{1'b0}};
    end else if (clear) begin
      q_valid   <= 1'b0;
      q_data    <= {DATA_W{1'b0}};
      q_pc      <= clear_pc;
      q_bd      <= 1'b0;
      q_exc     <= 1'b0;
      q_exccode <= {EXC_W{1'b0}};
    end else if (load) begin
      q_valid   <= d_valid;
      q_data    <= d_data;
      q_pc      <= d_pc;
      q_bd      <= d_bd;
      q_exc     <= d_exc;
      q_exccode <= d_exccode;
    end else begin
      q_valid   <= q_valid;
      q_data    <= q_data;
      q_pc      <= q_pc;
      q_bd      <= q_bd;
      q_exc     <= q_exc;
      q_exccode <= q_exccode;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, optional skid entry,
// EPC-preserving bubbles, exception flush and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 128,
  parameter int              PC_W     = 32,
  parameter int              SKID     = 1,
  parameter logic [PC_W-1:0] FLUSH_PC = PC_W'(FLUSH_PC_DEFAULT),
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic              in_exc,
  input  logic [EXC_W-1:0]  in_exccode,
  input  logic              bubble,
  input  logic              exc_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic              out_exc,
  output logic [EXC_W-1:0]  out_exccode,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              adv_s;
  logic              xfer_s;
  logic              bubble_take_s;
  logic              main_load_s;
  logic              main_d_valid_s;
  logic [DATA_W-1:0] main_d_data_s;
  logic [PC_W-1:0]   main_d_pc_s;
  logic              main_d_bd_s;
  logic              main_d_exc_s;
  logic [EXC_W-1:0]  main_d_exccode_s;
  logic              skid_load_s;
  logic              skid_clear_s;

  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [PC_W-1:0]   skid_pc_r;
  logic              skid_bd_r;
  logic              skid_exc_r;
  logic [EXC_W-1:0]  skid_exccode_r;

  // Handshake decode; with a skid the ready depends only on stage state.
  always_comb begin
    adv_s = !out_valid || out_ready;
    if (SKID != 32'sd0) begin
      in_ready = !skid_valid_r && !bubble;
    end else begin
      in_ready = adv_s && !bubble;
    end
    xfer_s        = in_valid && in_ready;
    bubble_take_s = bubble && !skid_valid_r && adv_s && !exc_flush;
  end

  // Next main-entry value: bubble keeps PC/BD so EPC is right on the bubble.
  always_comb begin
    main_load_s      = 1'b0;
    main_d_valid_s   = 1'b0;
    main_d_data_s    = out_data;
    main_d_pc_s      = out_pc;
    main_d_bd_s      = out_bd;
    main_d_exc_s     = out_exc;
    main_d_exccode_s = out_exccode;
    if (bubble_take_s) begin
      main_load_s      = 1'b1;
      main_d_data_s    = {DATA_W{1'b0}};
      main_d_pc_s      = in_pc;
      main_d_bd_s      = in_bd;
      main_d_exc_s     = 1'b0;
      main_d_exccode_s = {EXC_W{1'b0}};
    end else if (adv_s) begin
      main_load_s = 1'b1;
      if (skid_valid_r) begin
        main_d_valid_s   = 1'b1;
        main_d_data_s    = skid_data_r;
        main_d_pc_s      = skid_pc_r;
        main_d_bd_s      = skid_bd_r;
        main_d_exc_s     = skid_exc_r;
        main_d_exccode_s = skid_exccode_r;
      end else if (xfer_s) begin
        main_d_valid_s   = 1'b1;
        main_d_data_s    = in_data;
        main_d_pc_s      = in_pc;
        main_d_bd_s      = in_bd;
        main_d_exc_s     = in_exc;
        main_d_exccode_s = in_exccode;
      end else begin
        main_d_valid_s = 1'b0;
      end
    end else begin
      main_load_s = 1'b0;
    end
  end

  // Skid captures only when the main entry is stalled; it empties as main drains it.
  always_comb begin
    skid_clear_s = exc_flush || (adv_s && skid_valid_r);
    skid_load_s  = (SKID != 32'sd0) && !adv_s && xfer_s;
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (exc_flush),
    .load      (main_load_s),
    .clear_pc  (FLUSH_PC),
    .d_valid   (main_d_valid_s),
    .d_data    (main_d_data_s),
    .d_pc      (main_d_pc_s),
    .d_bd      (main_d_bd_s),
    .d_exc     (main_d_exc_s),
    .d_exccode (main_d_exccode_s),
    .q_valid   (out_valid),
    .q_data    (out_data),
    .q_pc      (out_pc),
    .q_bd      (out_bd),
    .q_exc     (out_exc),
    .q_exccode (out_exccode)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (skid_clear_s),
    .load      (skid_load_s),
    .clear_pc  ({PC_W{1'b0}}),
    .d_valid   (1'b1),
    .d_data    (in_data),
    .d_pc      (in_pc),
    .d_bd      (in_bd),
    .d_exc     (in_exc),
    .d_exccode (in_exccode),
    .q_valid   (skid_valid_r),
    .q_data    (skid_data_r),
    .q_pc      (skid_pc_r),
    .q_bd      (skid_bd_r),
    .q_exc     (skid_exc_r),
    .q_exccode (skid_exccode_r)
  );

  // Saturating count of bubbles actually loaded into the main entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (bubble_take_s && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed steps push expected outputs,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] FPC = 32'hBFC0_0380;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = 128'd0;
  logic [31:0]  in_pc = 32'd0;
  logic         in_bd = 1'b0;
  logic         in_exc = 1'b0;
  logic [4:0]   in_exccode = 5'd0;
  logic         bubble = 1'b0;
  logic         exc_flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [31:0]  out_pc;
  logic         out_bd;
  logic         out_exc;
  logic [4:0]   out_exccode;
  logic [1:0]   bubble_cnt;

  pipe_stage_reg #(
    .DATA_W(128), .PC_W(32), .SKID(1), .FLUSH_PC(FPC), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .in_bd(in_bd), .in_exc(in_exc), .in_exccode(in_exccode),
    .bubble(bubble), .exc_flush(exc_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .out_bd(out_bd), .out_exc(out_exc), .out_exccode(out_exccode),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [31:0]  pc;
    logic         bd;
    logic         exc;
    logic [4:0]   code;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic lat_strict = 1'b0;

  function automatic logic [127:0] mk_data(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, ~pc, pc, pc + 32'h1234_5678};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pop one expected entry per accepted output beat.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got pc %0h, required no output", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc", 128'(out_pc), 128'(mon_e.pc));
        chk("out_data", out_data, mon_e.data);
        chk("out_bd", 128'(out_bd), 128'(mon_e.bd));
        chk("out_exc", 128'(out_exc), 128'(mon_e.exc));
        chk("out_exccode", 128'(out_exccode), 128'(mon_e.code));
        if (lat_strict) chk("latency", 128'(cyc - mon_e.cyc), 128'(1));
      end
    end
  end

  // One clock: drive at posedge+1, sample handshake at negedge, push on accept.
  task automatic step(input logic v, input logic [31:0] pc, input logic bd, input logic exc,
                      input logic [4:0] code, input logic ordy, input logic bub, input logic fl,
                      output logic acc, output logic rdy);
    exp_t e;
    in_valid = v; in_pc = pc; in_data = mk_data(pc); in_bd = bd;
    in_exc = exc; in_exccode = code; out_ready = ordy; bubble = bub; exc_flush = fl;
    @(negedge clk);
    rdy = in_ready;
    acc = v && in_ready && !fl && !reset;
    if (acc) begin
      e.data = mk_data(pc); e.pc = pc; e.bd = bd; e.exc = exc; e.code = code; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic a, r;
    step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, ordy, 1'b0, 1'b0, a, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic acc, rdy;
    int   i;
    logic [31:0] pcs [4];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008; pcs[3] = 32'h300C;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_pc", 128'(out_pc), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_bubble_cnt", 128'(bubble_cnt), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Unstalled stream: one output per cycle, one cycle latency.
    lat_strict = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, pcs[k], 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, acc, rdy);
      chk("stream_accept", 128'(acc), 128'(1));
    end
    idle(1'b1); idle(1'b1);
    lat_strict = 1'b0;
    chk("stream_drained", 128'(exp_q.size()), 128'(0));
    chk("stream_bubble_cnt", 128'(bubble_cnt), 128'(0));

    // Downstream stall on the 2nd output: skid takes 0x3008, in_ready drops next cycle.
    i = 0;
    for (int k = 0; k < 10; k++) begin
      step(i < 4, pcs[i % 4], 1'b0, 1'b0, 5'd0, !(k == 2 || k == 3), 1'b0, 1'b0, acc, rdy);
      if (k == 2) chk("skid_ready_at_stall", 128'(rdy), 128'(1));
      if (k == 3) chk("skid_ready_after_stall", 128'(rdy), 128'(0));
      if (acc) i++;
    end
    chk("skid_all_sent", 128'(i), 128'(4));
    chk("skid_drained", 128'(exp_q.size()), 128'(0));

    // Two bubbles: input held off, PC/BD kept for EPC.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 32'h3010, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, acc, rdy);
      chk("bubble_not_consumed", 128'(acc), 128'(0));
    end
    chk("bubble_out_valid", 128'(out_valid), 128'(0));
    chk("bubble_out_pc", 128'(out_pc), 128'(32'h3010));
    chk("bubble_out_bd", 128'(out_bd), 128'(1));
    chk("bubble_out_data", out_data, 128'(0));
    chk("bubble_cnt_2", 128'(bubble_cnt), 128'(2));
    step(1'b1, 32'h3010, 1'b1, 1'b1, EXC_OV, 1'b1, 1'b0, 1'b0, acc, rdy);
    chk("post_bubble_accept", 128'(acc), 128'(1));
    idle(1'b1); idle(1'b1);

    // Flush with both entries full.
    step(1'b1, 32'h3020, 1'b1, 1'b1, EXC_ADEL, 1'b0, 1'b0, 1'b0, acc, rdy);
    step(1'b1, 32'h3024, 1'b0, 1'b1, EXC_RI, 1'b0, 1'b0, 1'b0, acc, rdy);
    chk("flush_skid_filled", 128'(acc), 128'(1));
    step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc, rdy);
    exp_q.delete();
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_out_pc", 128'(out_pc), 128'(FPC));
    chk("flush_out_exc", 128'(out_exc), 128'(0));
    chk("flush_out_bd", 128'(out_bd), 128'(0));
    chk("flush_skid_empty", 128'(in_ready), 128'(1));
    chk("flush_cnt_kept", 128'(bubble_cnt), 128'(2));
    idle(1'b1); idle(1'b1);

    // Priority: reset > flush > bubble.
    reset = 1'b1;
    step(1'b0, 32'h3030, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, acc, rdy);
    reset = 1'b0;
    chk("prio_all_cnt", 128'(bubble_cnt), 128'(0));
    chk("prio_all_pc", 128'(out_pc), 128'(0));
    step(1'b0, 32'h3030, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, acc, rdy);
    chk("prio_bub_cnt", 128'(bubble_cnt), 128'(1));
    chk("prio_bub_pc", 128'(out_pc), 128'(32'h3030));
    step(1'b0, 32'h3040, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, acc, rdy);
    chk("prio_flbub_pc", 128'(out_pc), 128'(FPC));
    chk("prio_flbub_bd", 128'(out_bd), 128'(0));
    chk("prio_flbub_cnt", 128'(bubble_cnt), 128'(1));
    step(1'b0, 32'h3050, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, acc, rdy);
    reset = 1'b1;
    step(1'b0, 32'h3058, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, acc, rdy);
    reset = 1'b0;
    chk("prio_rstbub_cnt", 128'(bubble_cnt), 128'(0));
    chk("prio_rstbub_pc", 128'(out_pc), 128'(0));
    step(1'b0, 32'h3060, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, acc, rdy);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, acc, rdy);
    reset = 1'b0;
    chk("prio_rstfl_pc", 128'(out_pc), 128'(0));

    // Saturation of the 2-bit counter.
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 32'h3070, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, acc, rdy);
      if (k == 2) chk("sat_cnt_2", 128'(bubble_cnt), 128'(2));
      if (k == 3) chk("sat_cnt_3", 128'(bubble_cnt), 128'(3));
    end
    chk("sat_cnt_5", 128'(bubble_cnt), 128'(3));
    idle(1'b1);
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
